// File: rtl/sdram_init_refresh_pkg.sv
// Shared SDRAM command encodings, timing helper and the init/refresh state type.
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;

  // Nanoseconds to whole clock cycles, rounded up; freq in MHz.
  function automatic int ns2cyc(input int ns, input int freq);
    return (ns * freq + 999) / 1000;
  endfunction

  typedef enum logic [3:0] {
    I_WAIT, I_PRE, I_TRP, I_REF, I_TRFC, I_MRS, I_TMRD,
    IDLE, R_PRE, R_TRP, R_REF, R_TRFC
  } state_t;

endpackage

// File: rtl/sdram_refresh_timer.sv
// tREFI tick generator and refresh debt counter with postponement limit and sticky overflow.
module sdram_refresh_timer #(
  parameter int C_REFI       = 1562,
  parameter int MAX_POSTPONE = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic dec,
  output logic ref_req,
  output logic ref_urgent,
  output logic ref_overflow
);

  localparam int TW = $clog2(C_REFI);

  logic [TW-1:0] tcnt;
  logic [3:0]    debt;
  logic          tick;

  assign tick       = enable && (tcnt == TW'(C_REFI - 1));
  assign ref_req    = (debt != 4'd0);
  assign ref_urgent = (debt == 4'(MAX_POSTPONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt         <= '0;
      debt         <= 4'd0;
      ref_overflow <= 1'b0;
    end else begin
      if (enable) tcnt <= tick ? '0 : tcnt + TW'(1);
      // A tick coinciding with a paid refresh cancels out and leaves debt as is.
      if (tick && !dec) begin
        if (debt == 4'(MAX_POSTPONE)) ref_overflow <= 1'b1;
        else                          debt         <= debt + 4'd1;
      end else if (!tick && dec && debt != 4'd0) begin
        debt <= debt - 4'd1;
      end
    end
  end

endmodule

// File: rtl/sdram_init_refresh.sv
// SDRAM power-up init and auto-refresh engine; owns the command bus while busy=1.
module sdram_init_refresh
  import sdram_pkg::*;
#(
  parameter int CLK_FREQ     = 100,
  parameter int RAW          = 12,
  parameter int INIT_TIME    = 100,
  parameter int tRP          = 18,
  parameter int tRFC         = 60,
  parameter int tREF         = 64,
  parameter int ROWS         = 4096,
  parameter int cMRD         = 2,
  parameter int INIT_REF_CNT = 2,
  parameter int MAX_POSTPONE = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [2:0]     cfg_burst_length,
  input  logic           cfg_burst_type,
  input  logic [2:0]     cfg_cas_latency,
  input  logic           cfg_burst_mode,
  input  logic           ref_gnt,
  output logic           init_done,
  output logic           ref_req,
  output logic           ref_urgent,
  output logic           ref_overflow,
  output logic           busy,
  output logic           sdram_cke,
  output logic           sdram_cs_n,
  output logic           sdram_ras_n,
  output logic           sdram_cas_n,
  output logic           sdram_we_n,
  output logic [RAW-1:0] sdram_addr,
  output logic [1:0]     sdram_ba
);

  localparam int C_INIT = INIT_TIME * CLK_FREQ;
  localparam int C_TRP  = ns2cyc(tRP, CLK_FREQ);
  localparam int C_TRFC = ns2cyc(tRFC, CLK_FREQ);
  localparam int C_REFI = (tREF * 1000 * CLK_FREQ) / ROWS;
  localparam int CW     = $clog2(C_INIT + 1);
  localparam logic [RAW-1:0] ADDR_A10 = RAW'(1 << 10);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [7:0]       ref_cnt;
  logic [3:0]       cmd;
  logic [RAW-1:0]   lmr_addr;

  assign lmr_addr = RAW'({cfg_burst_mode, 2'b00, cfg_cas_latency, cfg_burst_type, cfg_burst_length});
  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;

  sdram_refresh_timer #(
    .C_REFI       (C_REFI),
    .MAX_POSTPONE (MAX_POSTPONE)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (init_done),
    .dec          (state == R_REF),
    .ref_req      (ref_req),
    .ref_urgent   (ref_urgent),
    .ref_overflow (ref_overflow)
  );

  // Outputs are registered with the state: each command state drives its command for exactly
  // one cycle; wait states load cnt with (length - 2) because the command cycle counts as one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= I_WAIT;
      cnt       <= CW'(C_INIT - 1);
      ref_cnt   <= 8'd0;
      sdram_cke <= 1'b0;
      cmd       <= CMD_NOP;
      sdram_addr <= '0;
      sdram_ba  <= 2'b00;
      init_done <= 1'b0;
      busy      <= 1'b1;
    end else begin
      sdram_cke  <= 1'b1;
      cmd        <= CMD_NOP;
      sdram_addr <= '0;
      sdram_ba   <= 2'b00;
      case (state)
        I_WAIT: if (cnt == '0) begin
          state <= I_PRE; cmd <= CMD_PRE; sdram_addr <= ADDR_A10;
        end else cnt <= cnt - CW'(1);
        I_PRE: begin state <= I_TRP; cnt <= CW'(C_TRP - 2); end
        I_TRP: if (cnt == '0) begin
          state <= I_REF; cmd <= CMD_REF; ref_cnt <= ref_cnt + 8'd1;
        end else cnt <= cnt - CW'(1);
        I_REF: begin state <= I_TRFC; cnt <= CW'(C_TRFC - 2); end
        I_TRFC: if (cnt == '0) begin
          if (ref_cnt == 8'(INIT_REF_CNT)) begin
            state <= I_MRS; cmd <= CMD_LMR; sdram_addr <= lmr_addr;
          end else begin
            state <= I_REF; cmd <= CMD_REF; ref_cnt <= ref_cnt + 8'd1;
          end
        end else cnt <= cnt - CW'(1);
        I_MRS: begin state <= I_TMRD; cnt <= CW'(cMRD - 2); end
        I_TMRD: if (cnt == '0) begin
          state <= IDLE; init_done <= 1'b1; busy <= 1'b0;
        end else cnt <= cnt - CW'(1);
        IDLE: if (ref_req && ref_gnt) begin
          state <= R_PRE; busy <= 1'b1; cmd <= CMD_PRE; sdram_addr <= ADDR_A10;
        end
        R_PRE: begin state <= R_TRP; cnt <= CW'(C_TRP - 2); end
        R_TRP: if (cnt == '0) begin
          state <= R_REF; cmd <= CMD_REF;
        end else cnt <= cnt - CW'(1);
        R_REF: begin state <= R_TRFC; cnt <= CW'(C_TRFC - 2); end
        // Debt is re-read here so ticks that land mid-burst lengthen the burst.
        R_TRFC: if (cnt == '0) begin
          if (ref_req) begin
            state <= R_REF; cmd <= CMD_REF;
          end else begin
            state <= IDLE; busy <= 1'b0;
          end
        end else cnt <= cnt - CW'(1);
        default: state <= I_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_init_refresh.sv
// Directed bench for sdram_init_refresh: cycle-indexed expectation table plus corner sequences.
module tb_sdram_init_refresh;
  import sdram_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  cfg_burst_length = 3'b011;
  logic        cfg_burst_type = 1'b0;
  logic [2:0]  cfg_cas_latency = 3'b011;
  logic        cfg_burst_mode = 1'b1;
  logic        ref_gnt = 1'b1;
  logic        init_done, ref_req, ref_urgent, ref_overflow, busy, sdram_cke;
  logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [11:0] sdram_addr;
  logic [1:0]  sdram_ba;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  sdram_init_refresh dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_burst_length(cfg_burst_length), .cfg_burst_type(cfg_burst_type),
    .cfg_cas_latency(cfg_cas_latency), .cfg_burst_mode(cfg_burst_mode),
    .ref_gnt(ref_gnt), .init_done(init_done), .ref_req(ref_req),
    .ref_urgent(ref_urgent), .ref_overflow(ref_overflow), .busy(busy),
    .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_addr(sdram_addr), .sdram_ba(sdram_ba)
  );

  // clock / cycle index: cycle 0 is the cycle in which rst_n is released
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  // flags = {cke, init_done, busy, ref_req, ref_urgent, ref_overflow}
  typedef struct {
    int          cyc;
    logic        gnt;
    logic [3:0]  cmd;
    logic [11:0] addr;
    logic [5:0]  flags;
  } row_t;

  row_t tbl[$];

  function automatic row_t mk(input int c, input logic g, input logic [3:0] cm,
                              input logic [11:0] a, input logic [5:0] f);
    row_t r;
    r.cyc = c; r.gnt = g; r.cmd = cm; r.addr = a; r.flags = f;
    return r;
  endfunction

  task automatic cmp(input string name, input logic [3:0] cm, input logic [11:0] a,
                     input logic [5:0] f);
    logic [23:0] act, exp;
    act = {sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, init_done, busy,
           ref_req, ref_urgent, ref_overflow, sdram_ba, sdram_addr};
    exp = {f[5], cm, f[4:0], 2'b00, a};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h (cke,cmd,done,busy,req,urg,ovf,ba,addr)",
               name, cyc, act, exp);
    end
  endtask

  task automatic check(input string name, input int t, input logic [3:0] cm,
                       input logic [11:0] a, input logic [5:0] f);
    while (cyc < t) @(negedge clk);
    cmp(name, cm, a, f);
  endtask

  task automatic reset_pulse(input string name);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    cmp(name, CMD_NOP, 12'h000, 6'b001000);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // init sequence, cfg 0x233
    tbl.push_back(mk(0,     1, CMD_NOP, 12'h000, 6'b001000));
    tbl.push_back(mk(1,     1, CMD_NOP, 12'h000, 6'b101000));
    tbl.push_back(mk(9999,  1, CMD_NOP, 12'h000, 6'b101000));
    tbl.push_back(mk(10000, 1, CMD_PRE, 12'h400, 6'b101000));
    tbl.push_back(mk(10001, 1, CMD_NOP, 12'h000, 6'b101000));
    tbl.push_back(mk(10002, 1, CMD_REF, 12'h000, 6'b101000));
    tbl.push_back(mk(10007, 1, CMD_NOP, 12'h000, 6'b101000));
    tbl.push_back(mk(10008, 1, CMD_REF, 12'h000, 6'b101000));
    tbl.push_back(mk(10013, 1, CMD_NOP, 12'h000, 6'b101000));
    tbl.push_back(mk(10014, 1, CMD_LMR, 12'h233, 6'b101000));
    tbl.push_back(mk(10015, 1, CMD_NOP, 12'h000, 6'b101000));
    tbl.push_back(mk(10016, 1, CMD_NOP, 12'h000, 6'b110000));
    // periodic refresh with grant held high
    tbl.push_back(mk(11577, 1, CMD_NOP, 12'h000, 6'b110000));
    tbl.push_back(mk(11578, 1, CMD_NOP, 12'h000, 6'b110100));
    tbl.push_back(mk(11579, 1, CMD_PRE, 12'h400, 6'b111100));
    tbl.push_back(mk(11580, 1, CMD_NOP, 12'h000, 6'b111100));
    tbl.push_back(mk(11581, 1, CMD_REF, 12'h000, 6'b111100));
    tbl.push_back(mk(11582, 1, CMD_NOP, 12'h000, 6'b111000));
    tbl.push_back(mk(11586, 1, CMD_NOP, 12'h000, 6'b111000));
    tbl.push_back(mk(11587, 1, CMD_NOP, 12'h000, 6'b110000));
    tbl.push_back(mk(13140, 1, CMD_NOP, 12'h000, 6'b110100));
    tbl.push_back(mk(13141, 1, CMD_PRE, 12'h400, 6'b111100));
    tbl.push_back(mk(13143, 1, CMD_REF, 12'h000, 6'b111100));
    tbl.push_back(mk(13149, 0, CMD_NOP, 12'h000, 6'b110000));
    // postpone 8 refreshes, then pay back in one burst
    tbl.push_back(mk(14702, 0, CMD_NOP, 12'h000, 6'b110100));
    tbl.push_back(mk(14703, 0, CMD_NOP, 12'h000, 6'b110100));
    tbl.push_back(mk(25635, 0, CMD_NOP, 12'h000, 6'b110100));
    tbl.push_back(mk(25636, 1, CMD_NOP, 12'h000, 6'b110110));
    tbl.push_back(mk(25637, 1, CMD_PRE, 12'h400, 6'b111110));
    tbl.push_back(mk(25639, 1, CMD_REF, 12'h000, 6'b111110));
    tbl.push_back(mk(25640, 1, CMD_NOP, 12'h000, 6'b111100));
    for (int k = 1; k < 8; k++)
      tbl.push_back(mk(25639 + 6 * k, 1, CMD_REF, 12'h000, 6'b111100));
    tbl.push_back(mk(25682, 1, CMD_NOP, 12'h000, 6'b111000));
    tbl.push_back(mk(25686, 1, CMD_NOP, 12'h000, 6'b111000));
    tbl.push_back(mk(25687, 0, CMD_NOP, 12'h000, 6'b110000));
    // overflow: ninth tick at full debt
    tbl.push_back(mk(38131, 0, CMD_NOP, 12'h000, 6'b110100));
    tbl.push_back(mk(38132, 0, CMD_NOP, 12'h000, 6'b110110));
    tbl.push_back(mk(39693, 0, CMD_NOP, 12'h000, 6'b110110));
    tbl.push_back(mk(39694, 1, CMD_NOP, 12'h000, 6'b110111));
    tbl.push_back(mk(39695, 1, CMD_PRE, 12'h400, 6'b111111));
    tbl.push_back(mk(39697, 1, CMD_REF, 12'h000, 6'b111111));
    tbl.push_back(mk(39698, 1, CMD_NOP, 12'h000, 6'b111101));
    tbl.push_back(mk(39739, 1, CMD_REF, 12'h000, 6'b111101));
    tbl.push_back(mk(39740, 1, CMD_NOP, 12'h000, 6'b111001));
    tbl.push_back(mk(39745, 0, CMD_NOP, 12'h000, 6'b110001));

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      check($sformatf("vec%0d", i), tbl[i].cyc, tbl[i].cmd, tbl[i].addr, tbl[i].flags);
      ref_gnt = tbl[i].gnt;
    end

    // tick lands on an R_REF cycle: debt holds, burst gets one extra refresh
    check("tick_debt1", 41256, CMD_NOP, 12'h000, 6'b110101);
    check("tick_pregnt", 42814, CMD_NOP, 12'h000, 6'b110101);
    ref_gnt = 1'b1;
    check("tick_pre", 42815, CMD_PRE, 12'h400, 6'b111101);
    check("tick_ref1", 42817, CMD_REF, 12'h000, 6'b111101);
    check("tick_debt_held", 42818, CMD_NOP, 12'h000, 6'b111101);
    check("tick_trfc_end", 42822, CMD_NOP, 12'h000, 6'b111101);
    check("tick_ref2", 42823, CMD_REF, 12'h000, 6'b111101);
    check("tick_paid", 42824, CMD_NOP, 12'h000, 6'b111001);
    check("tick_idle", 42829, CMD_NOP, 12'h000, 6'b110001);

    // reset in the middle of a refresh burst
    check("burst_pre", 44381, CMD_PRE, 12'h400, 6'b111101);
    check("burst_trp", 44382, CMD_NOP, 12'h000, 6'b111101);
    reset_pulse("rst_mid_burst");
    check("rst_c0", 0, CMD_NOP, 12'h000, 6'b001000);
    check("rst_c1", 1, CMD_NOP, 12'h000, 6'b101000);

    // reset in the middle of the power-up wait, then a different mode word
    check("init_wait", 5000, CMD_NOP, 12'h000, 6'b101000);
    reset_pulse("rst_mid_init");
    cfg_burst_length = 3'b010;
    cfg_burst_type   = 1'b1;
    cfg_cas_latency  = 3'b010;
    cfg_burst_mode   = 1'b0;
    check("re_c0", 0, CMD_NOP, 12'h000, 6'b001000);
    check("re_9999", 9999, CMD_NOP, 12'h000, 6'b101000);
    check("re_pre", 10000, CMD_PRE, 12'h400, 6'b101000);
    check("re_ref1", 10002, CMD_REF, 12'h000, 6'b101000);
    check("re_ref2", 10008, CMD_REF, 12'h000, 6'b101000);
    check("re_lmr", 10014, CMD_LMR, 12'h02a, 6'b101000);
    check("re_tmrd", 10015, CMD_NOP, 12'h000, 6'b101000);
    check("re_done", 10016, CMD_NOP, 12'h000, 6'b110000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
